// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 register-file types, register addresses and MTC0 write masks.
package cp0_regfile_pkg;

    typedef struct packed {
        logic [31:0] badvaddr;
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] errorepc;
    } cp0_t;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_ERROREPC = 5'd30;

    localparam logic [31:0] MASK_STATUS = 32'h0000_FF03;
    localparam logic [31:0] MASK_CAUSE  = 32'h0000_0300;
    localparam logic [31:0] MASK_ALL    = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_NONE   = 32'h0000_0000;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exccode_t;

    // Bits of each register that MTC0 is allowed to change.
    function automatic logic [31:0] cp0_mask(input logic [4:0] addr);
        case (addr)
            CP0_STATUS:   cp0_mask = MASK_STATUS;
            CP0_CAUSE:    cp0_mask = MASK_CAUSE;
            CP0_COUNT,
            CP0_COMPARE,
            CP0_EPC,
            CP0_ERROREPC: cp0_mask = MASK_ALL;
            default:      cp0_mask = MASK_NONE;
        endcase
    endfunction

    function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/cp0_regfile_count_timer.sv
// Count/Compare timer: prescaled free-running Count, Compare register and
// the sticky timer-interrupt flag TI.
module cp0_count_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic [31:0]      count_r;
    logic [31:0]      compare_r;
    logic             ti_r;
    logic [31:0]      count_inc_s;
    logic             tick_s;
    logic             match_s;

    // Increment enable and match detect; a Count write suppresses the increment.
    always_comb begin
        count_inc_s = count_r + 32'd1;
        tick_s      = (div_r == DIV_LAST) && !count_we;
        match_s     = tick_s && (count_inc_s == compare_r);
    end

    // Prescaler and Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r   <= '0;
            count_r <= 32'd0;
        end else if (count_we) begin
            div_r   <= '0;
            count_r <= wr_data;
        end else if (tick_s) begin
            div_r   <= '0;
            count_r <= count_inc_s;
        end else begin
            div_r   <= div_r + DIV_W'(1);
        end
    end

    // Compare register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            compare_r <= 32'd0;
        end else if (compare_we) begin
            compare_r <= wr_data;
        end
    end

    // TI is sticky; only a Compare write clears it, and that write beats a same-cycle match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ti_r <= 1'b0;
        end else if (compare_we) begin
            ti_r <= 1'b0;
        end else if (match_s) begin
            ti_r <= 1'b1;
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign ti      = ti_r;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MFC0/MTC0 access, interrupt sampling, exception entry
// and ERET handling, with the Count/Compare timer in a sub-module.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter int          N_HWINT      = 6,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_HWINT-1:0] ext_int,
    input  logic [4:0]         rd_addr,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic [4:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic               exc_valid,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        exc_pc,
    input  logic               exc_in_delay,
    input  logic [31:0]        exc_badvaddr,
    input  logic               eret,
    output logic [31:0]        epc,
    output logic               int_pending,
    output cp0_t               cp0
);
    logic [N_HWINT-1:0] ext_int_q_r;
    logic [31:0]        status_r;
    logic [31:0]        epc_r;
    logic [31:0]        errorepc_r;
    logic [31:0]        badvaddr_r;
    logic               bd_r;
    logic [1:0]         sw_ip_r;
    logic [4:0]         exccode_r;

    logic [31:0]        count_s;
    logic [31:0]        compare_s;
    logic               ti_s;
    logic               wr_ok_s;
    logic               exc_first_s;
    logic               exc_addr_s;
    logic [31:0]        status_w_s;
    logic               exl_n_s;
    logic [5:0]         hw_pend_s;
    logic [7:0]         ip_s;
    logic [31:0]        cause_s;

    // A committing exception squashes any MTC0 in the same cycle.
    assign wr_ok_s     = wr_en & ~exc_valid;
    assign exc_first_s = exc_valid & ~status_r[ST_EXL];
    assign exc_addr_s  = (exc_code == EXC_ADEL) || (exc_code == EXC_ADES);

    cp0_count_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wr_ok_s && (wr_addr == CP0_COUNT)),
        .compare_we (wr_ok_s && (wr_addr == CP0_COMPARE)),
        .wr_data    (wr_data),
        .count      (count_s),
        .compare    (compare_s),
        .ti         (ti_s)
    );

    // Status next value: masked MTC0 first, then exception sets EXL, ERET clears it.
    always_comb begin
        if (wr_ok_s && (wr_addr == CP0_STATUS)) begin
            status_w_s = masked_write(status_r, wr_data, cp0_mask(wr_addr));
        end else begin
            status_w_s = status_r;
        end
        if (exc_valid) begin
            exl_n_s = 1'b1;
        end else if (eret) begin
            exl_n_s = 1'b0;
        end else begin
            exl_n_s = status_w_s[ST_EXL];
        end
    end

    // Cause view: hardware lines occupy IP2 upward and IP7 also carries TI.
    always_comb begin
        hw_pend_s              = 6'd0;
        hw_pend_s[N_HWINT-1:0] = ext_int_q_r;
        ip_s    = {hw_pend_s[5] | ti_s, hw_pend_s[4:0], sw_ip_r};
        cause_s = {bd_r, ti_s, 14'd0, ip_s, 1'b0, exccode_r, 2'b00};
    end

    // Interrupt line sampling and Status register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_int_q_r <= '0;
            status_r    <= RESET_STATUS;
        end else begin
            ext_int_q_r <= ext_int;
            status_r    <= {status_w_s[31:2], exl_n_s, status_w_s[0]};
        end
    end

    // Cause bookkeeping; BD only records the first exception of a nest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bd_r      <= 1'b0;
            exccode_r <= 5'd0;
            sw_ip_r   <= 2'b00;
        end else begin
            if (exc_valid) begin
                exccode_r <= exc_code;
            end
            if (exc_first_s) begin
                bd_r <= exc_in_delay;
            end
            if (wr_ok_s && (wr_addr == CP0_CAUSE)) begin
                sw_ip_r <= wr_data[9:8];
            end
        end
    end

    // EPC, ErrorEPC and BadVAddr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_r      <= 32'd0;
            errorepc_r <= 32'd0;
            badvaddr_r <= 32'd0;
        end else begin
            if (exc_first_s) begin
                epc_r <= exc_in_delay ? (exc_pc - 32'd4) : exc_pc;
            end else if (wr_ok_s && (wr_addr == CP0_EPC)) begin
                epc_r <= wr_data;
            end
            if (wr_ok_s && (wr_addr == CP0_ERROREPC)) begin
                errorepc_r <= wr_data;
            end
            if (exc_valid && exc_addr_s) begin
                badvaddr_r <= exc_badvaddr;
            end
        end
    end

    // MFC0 read mux, no bypass of this cycle's write.
    always_comb begin
        case (rd_addr)
            CP0_BADVADDR: rd_data = badvaddr_r;
            CP0_COUNT:    rd_data = count_s;
            CP0_COMPARE:  rd_data = compare_s;
            CP0_STATUS:   rd_data = status_r;
            CP0_CAUSE:    rd_data = cause_s;
            CP0_EPC:      rd_data = epc_r;
            CP0_ERROREPC: rd_data = errorepc_r;
            default:      rd_data = 32'd0;
        endcase
    end

    assign int_pending = status_r[ST_IE] & ~status_r[ST_EXL] & (|(ip_s & status_r[15:8]));
    assign epc         = epc_r;
    assign cp0         = '{badvaddr: badvaddr_r, count: count_s, compare: compare_s,
                           status: status_r, cause: cause_s, epc: epc_r,
                           errorepc: errorepc_r};

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomised bench for cp0_regfile with a behavioural CP0 model and a
// per-cycle comparison of every output, plus directed literal checks.
module tb_cp0_regfile;
    import cp0_regfile_pkg::*;

    localparam int          N_HWINT      = 6;
    localparam int          COUNT_DIV    = 2;
    localparam logic [31:0] RESET_STATUS = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  ext_int;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [31:0] epc;
    logic        int_pending;
    cp0_t        cp0;

    cp0_regfile #(
        .N_HWINT (N_HWINT), .COUNT_DIV (COUNT_DIV), .RESET_STATUS (RESET_STATUS)
    ) dut (
        .clk (clk), .reset (reset), .ext_int (ext_int), .rd_addr (rd_addr),
        .rd_data (rd_data), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .exc_valid (exc_valid), .exc_code (exc_code), .exc_pc (exc_pc),
        .exc_in_delay (exc_in_delay), .exc_badvaddr (exc_badvaddr), .eret (eret),
        .epc (epc), .int_pending (int_pending), .cp0 (cp0)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural model state
    logic [31:0] m_count, m_compare, m_status, m_epc, m_errorepc, m_badvaddr;
    logic        m_ti, m_bd;
    logic [1:0]  m_swip;
    logic [4:0]  m_exc;
    logic [5:0]  m_ext;
    int          m_phase;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_cause();
        logic [7:0] ip;
        ip = {m_ext[5] | m_ti, m_ext[4:0], m_swip};
        return {m_bd, m_ti, 14'd0, ip, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic m_pend();
        logic [31:0] c;
        c = m_cause();
        return m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badvaddr;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd30:   return m_errorepc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_count = 32'd0; m_compare = 32'd0; m_status = RESET_STATUS;
        m_epc = 32'd0; m_errorepc = 32'd0; m_badvaddr = 32'd0;
        m_ti = 1'b0; m_bd = 1'b0; m_swip = 2'b00; m_exc = 5'd0; m_ext = 6'd0;
        m_phase = 0;
    endtask

    // One clock: derive the architectural next state from the current inputs.
    task automatic tick();
        logic [31:0] n_count = m_count, n_compare = m_compare, n_status = m_status;
        logic [31:0] n_epc = m_epc, n_errorepc = m_errorepc, n_badvaddr = m_badvaddr;
        logic        n_ti = m_ti, n_bd = m_bd;
        logic [1:0]  n_swip = m_swip;
        logic [4:0]  n_exc = m_exc;
        int          n_phase;
        bit          we, inc;
        we  = wr_en && !exc_valid;
        inc = 1'b0;
        if (we && wr_addr == 5'd9) begin
            n_count = wr_data; n_phase = 0;
        end else if (m_phase + 1 == COUNT_DIV) begin
            n_count = m_count + 32'd1; n_phase = 0; inc = 1'b1;
        end else begin
            n_phase = m_phase + 1;
        end
        if (we && wr_addr == 5'd11) begin
            n_compare = wr_data; n_ti = 1'b0;
        end else if (inc && n_count == m_compare) begin
            n_ti = 1'b1;
        end
        if (we && wr_addr == 5'd12)
            n_status = (m_status & ~32'h0000_FF03) | (wr_data & 32'h0000_FF03);
        if (we && wr_addr == 5'd13) n_swip = wr_data[9:8];
        if (we && wr_addr == 5'd14) n_epc = wr_data;
        if (we && wr_addr == 5'd30) n_errorepc = wr_data;
        if (exc_valid) begin
            if (!m_status[1]) begin
                n_epc = exc_in_delay ? exc_pc - 32'd4 : exc_pc;
                n_bd  = exc_in_delay;
            end
            n_exc = exc_code;
            n_status[1] = 1'b1;
            if (exc_code == 5'd4 || exc_code == 5'd5) n_badvaddr = exc_badvaddr;
        end else if (eret) begin
            n_status[1] = 1'b0;
        end
        @(posedge clk);
        m_count = n_count; m_compare = n_compare; m_status = n_status;
        m_epc = n_epc; m_errorepc = n_errorepc; m_badvaddr = n_badvaddr;
        m_ti = n_ti; m_bd = n_bd; m_swip = n_swip; m_exc = n_exc;
        m_ext = ext_int; m_phase = n_phase;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic dly,
                       input logic [31:0] bva);
        exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_in_delay = dly; exc_badvaddr = bva;
        tick();
        exc_valid = 1'b0;
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Every falling edge: all outputs against the model
    always @(negedge clk) begin
        chk("rd_data", rd_data, m_read(rd_addr));
        chk("epc", epc, m_epc);
        chk("int_pending", {31'd0, int_pending}, {31'd0, m_pend()});
        chk("cp0.count", cp0.count, m_count);
        chk("cp0.compare", cp0.compare, m_compare);
        chk("cp0.status", cp0.status, m_status);
        chk("cp0.cause", cp0.cause, m_cause());
        chk("cp0.epc", cp0.epc, m_epc);
        chk("cp0.badvaddr", cp0.badvaddr, m_badvaddr);
        chk("cp0.errorepc", cp0.errorepc, m_errorepc);
    end

    initial begin
        reset = 1'b1; ext_int = 6'd0; rd_addr = 5'd12; wr_en = 1'b0; wr_addr = 5'd0;
        wr_data = 32'd0; exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0;
        exc_in_delay = 1'b0; exc_badvaddr = 32'd0; eret = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_status", rd_data, 32'h0040_0000);
        chk("reset_int_pending", {31'd0, int_pending}, 32'd0);
        chk("reset_epc", epc, 32'd0);

        repeat (10) tick();
        rd_addr = 5'd9; #1;
        chk("count_after_10", rd_data, 32'd5);

        wr(5'd12, 32'hFFFF_FFFF); rd_addr = 5'd12; #1;
        chk("status_mask", rd_data, 32'h0040_FF03);
        wr(5'd13, 32'hFFFF_FFFF); rd_addr = 5'd13; #1;
        chk("cause_mask", rd_data, 32'h0000_0300);
        wr(5'd8, 32'h0000_0001); rd_addr = 5'd8; #1;
        chk("badvaddr_ro", rd_data, 32'd0);

        wr(5'd11, 32'd8);
        wr(5'd12, 32'h0000_8001);
        wr(5'd13, 32'd0);
        for (int i = 0; i < 8 && m_count != 32'd8; i++) tick();
        chk("count_at_match", cp0.count, 32'd8);
        chk("ti_set", {31'd0, cp0.cause[30]}, 32'd1);
        chk("ip7_set", {31'd0, cp0.cause[15]}, 32'd1);
        chk("timer_int_pending", {31'd0, int_pending}, 32'd1);
        wr(5'd11, 32'd0);
        chk("ti_cleared", {31'd0, cp0.cause[30]}, 32'd0);
        chk("int_pending_cleared", {31'd0, int_pending}, 32'd0);

        exc(5'd4, 32'hBFC0_0104, 1'b1, 32'h1234_5671);
        chk("exc_epc", epc, 32'hBFC0_0100);
        chk("exc_cause", cp0.cause, 32'h8000_0010);
        chk("exc_badvaddr", cp0.badvaddr, 32'h1234_5671);
        chk("exc_exl", {31'd0, cp0.status[1]}, 32'd1);
        exc(5'd8, 32'h0000_0100, 1'b0, 32'hDEAD_BEEF);
        chk("nested_epc", epc, 32'hBFC0_0100);
        chk("nested_cause", cp0.cause, 32'h8000_0020);
        chk("nested_badvaddr", cp0.badvaddr, 32'h1234_5671);

        eret = 1'b1; tick(); eret = 1'b0;
        chk("eret_exl", {31'd0, cp0.status[1]}, 32'd0);
        eret = 1'b1; exc(5'd12, 32'h0000_0200, 1'b0, 32'd0); eret = 1'b0;
        chk("exc_beats_eret", {31'd0, cp0.status[1]}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h0000_0055;
        exc(5'd9, 32'h0000_0300, 1'b0, 32'd0);
        wr_en = 1'b0;
        chk("exc_drops_write", cp0.compare, 32'd0);

        eret = 1'b1; tick(); eret = 1'b0;
        ext_int = 6'b000001;
        wr(5'd12, 32'h0000_0401);
        chk("ip2_sampled", {31'd0, cp0.cause[10]}, 32'd1);
        chk("hw_int_pending", {31'd0, int_pending}, 32'd1);

        #1 reset = 1'b1;
        ext_int = 6'd0;
        model_reset();
        #1;
        chk("midreset_status", cp0.status, 32'h0040_0000);
        chk("midreset_cause", cp0.cause, 32'd0);
        chk("midreset_epc", cp0.epc, 32'd0);
        chk("midreset_badvaddr", cp0.badvaddr, 32'd0);
        chk("midreset_int_pending", {31'd0, int_pending}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            wr_en = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0:       wr_addr = 5'd8;
                1:       wr_addr = 5'd9;
                2:       wr_addr = 5'd11;
                3:       wr_addr = 5'd12;
                4:       wr_addr = 5'd13;
                5:       wr_addr = 5'd14;
                6:       wr_addr = 5'd30;
                default: wr_addr = 5'($urandom);
            endcase
            wr_data = $urandom;
            if (wr_addr == 5'd11 && $urandom_range(0, 1) == 1)
                wr_data = m_count + 32'($urandom_range(0, 3));
            if (wr_addr == 5'd9 && $urandom_range(0, 1) == 1)
                wr_data = m_compare - 32'($urandom_range(1, 3));
            exc_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 7))
                0:       exc_code = 5'd0;
                1:       exc_code = 5'd4;
                2:       exc_code = 5'd5;
                3:       exc_code = 5'd8;
                4:       exc_code = 5'd10;
                5:       exc_code = 5'd12;
                default: exc_code = 5'($urandom);
            endcase
            exc_pc       = $urandom;
            exc_in_delay = 1'($urandom);
            exc_badvaddr = $urandom;
            eret         = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) ext_int = 6'($urandom);
            case ($urandom_range(0, 7))
                0:       rd_addr = 5'd8;
                1:       rd_addr = 5'd9;
                2:       rd_addr = 5'd11;
                3:       rd_addr = 5'd12;
                4:       rd_addr = 5'd13;
                5:       rd_addr = 5'd14;
                6:       rd_addr = 5'd30;
                default: rd_addr = 5'($urandom);
            endcase
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
